// File: rtl/sparse_write_stage.sv
// Sparse layer writer: drops zero activations from a dense stream and writes each
// nonzero as a (value, position) pair to the paired data/position memories, then
// closes the layer with a sentinel entry whose position is all ones.
module sparse_write_stage #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_rdy,
   input  logic              mem_wr_rdy,
   output logic              wren,
   output logic [ADDR_W-1:0] wraddr,
   output logic [31:0]       wrdata,
   output logic [31:0]       wrdataPosition,
   output logic [31:0]       nz_count,
   output logic              overflow,
   output logic              layer_done
);

   typedef enum logic [1:0] {StIdle, StRun, StTerm, StDone} state_e;

   localparam logic [ADDR_W-1:0] StepA    = ADDR_W'(ADDR_STEP);
   // Top slot of the address space is kept free for the sentinel.
   localparam logic [ADDR_W-1:0] LastSlot = {ADDR_W{1'b0}} - StepA;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [31:0]       pos_q, pos_d;
   logic              sent_q, sent_d;   // sentinel loaded into the write buffer
   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] wraddr_q, wraddr_d;
   logic [31:0]       wrdata_q, wrdata_d;
   logic [31:0]       wrpos_q, wrpos_d;
   logic [31:0]       nz_q, nz_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   logic buf_free;
   logic accept;

   // Write buffer can take a new entry when empty or draining this cycle.
   always_comb begin
      buf_free = !wren_q || mem_wr_rdy;
      in_rdy   = (state_q == StRun) && buf_free;
      accept   = in_valid && in_rdy;
   end

   // Next-state: layer sequencing, zero drop, write buffer loading and sentinel.
   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      pos_d       = pos_q;
      sent_d      = sent_q;
      wren_d      = wren_q;
      wraddr_d    = wraddr_q;
      wrdata_d    = wrdata_q;
      wrpos_d     = wrpos_q;
      nz_d        = nz_q;
      ovf_d       = ovf_q;
      done_d      = done_q;

      if (wren_q && mem_wr_rdy) begin
         wren_d = 1'b0;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StRun;
               next_addr_d = '0;
               pos_d       = '0;
               nz_d        = '0;
               ovf_d       = 1'b0;
               done_d      = 1'b0;
               sent_d      = 1'b0;
            end
         end
         StRun: begin
            if (accept) begin
               pos_d = pos_q + 32'd1;
               if (in_data != 32'd0) begin
                  if (next_addr_q != LastSlot) begin
                     wren_d      = 1'b1;
                     wraddr_d    = next_addr_q;
                     wrdata_d    = in_data;
                     wrpos_d     = pos_q;
                     next_addr_d = next_addr_q + StepA;
                     nz_d        = nz_q + 32'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               if (in_last) begin
                  state_d = StTerm;
               end
            end
         end
         StTerm: begin
            if (!sent_q) begin
               if (buf_free) begin
                  wren_d   = 1'b1;
                  wraddr_d = next_addr_q;
                  wrdata_d = 32'd0;
                  wrpos_d  = 32'hFFFF_FFFF;
                  sent_d   = 1'b1;
               end
            end else if (mem_wr_rdy) begin
               // wren_q is necessarily set here; it clears via the drain above.
               state_d = StDone;
               sent_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         next_addr_q <= '0;
         pos_q       <= '0;
         sent_q      <= 1'b0;
         wren_q      <= 1'b0;
         wraddr_q    <= '0;
         wrdata_q    <= '0;
         wrpos_q     <= '0;
         nz_q        <= '0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         pos_q       <= pos_d;
         sent_q      <= sent_d;
         wren_q      <= wren_d;
         wraddr_q    <= wraddr_d;
         wrdata_q    <= wrdata_d;
         wrpos_q     <= wrpos_d;
         nz_q        <= nz_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   end

   assign wren           = wren_q;
   assign wraddr         = wraddr_q;
   assign wrdata         = wrdata_q;
   assign wrdataPosition = wrpos_q;
   assign nz_count       = nz_q;
   assign overflow       = ovf_q;
   assign layer_done     = done_q;

endmodule
